// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad column scanner, per-scan debounce, hex encode
// Revision 1.0
// ============================================================================
module keypad_scanner #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int SCAN_RATE      = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int c_step_raw = CLK_FREQ / (SCAN_RATE * 4);
  localparam int c_step_max = (c_step_raw < 2) ? 2 : c_step_raw;
  localparam int c_step_w   = $clog2(c_step_max);
  localparam int c_cnt_w    = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(c_step_max - 1);
  localparam logic [c_cnt_w-1:0]  c_deb       = c_cnt_w'(DEBOUNCE_SCANS);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

  // Entry (row*4 + col) holds the hex code printed on that key.
  localparam logic [63:0] c_keymap = 64'hDEF0_C987_B654_A321;

  localparam logic [1:0] c_out_none   = 2'd0;
  localparam logic [1:0] c_out_single = 2'd1;
  localparam logic [1:0] c_out_multi  = 2'd2;

  localparam logic [0:0] c_st_idle    = 1'b0;
  localparam logic [0:0] c_st_pressed = 1'b1;

  logic [3:0]          row_meta_q, row_sync_q;
  logic [c_step_w-1:0] step_q;
  logic [1:0]          col_idx_q;
  logic [15:0]         scan_q;
  logic [1:0]          prev_type_q;
  logic [3:0]          prev_code_q;
  logic [c_cnt_w-1:0]  cnt_q;
  logic [0:0]          state_q, state_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;

  logic                w_step_end, w_scan_end, w_same, w_stable;
  logic [15:0]         w_scan_full;
  logic [1:0]          w_out_type;
  logic [3:0]          w_out_code;
  logic [c_cnt_w-1:0]  w_cnt_next;

  assign w_step_end = (step_q == c_step_last);
  assign w_scan_end = w_step_end && (col_idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      step_q     <= '0;
      col_idx_q  <= 2'd0;
      scan_q     <= '0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      if (w_step_end) begin
        step_q    <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        scan_q    <= w_scan_full;
      end else begin
        step_q <= step_q + 1'b1;
      end
    end
  end

  // Current scan image with the column being sampled this cycle merged in.
  always_comb begin
    w_scan_full = scan_q;
    for (int r = 0; r < 4; r++) begin
      w_scan_full[{2'(r), col_idx_q}] = ~row_sync_q[r];
    end
  end

  always_comb begin
    w_out_type = c_out_none;
    w_out_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (w_scan_full[i]) begin
        if (w_out_type == c_out_none) begin
          w_out_type = c_out_single;
          w_out_code = c_keymap[4*i +: 4];
        end else begin
          w_out_type = c_out_multi;
          w_out_code = 4'h0;
        end
      end
    end
  end

  assign w_same     = (w_out_type == prev_type_q) && (w_out_code == prev_code_q);
  assign w_cnt_next = !w_same ? c_cnt_one : ((cnt_q == c_deb) ? cnt_q : cnt_q + 1'b1);
  assign w_stable   = (w_cnt_next == c_deb);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_type_q <= c_out_none;
      prev_code_q <= 4'h0;
      cnt_q       <= '0;
    end else if (w_scan_end) begin
      prev_type_q <= w_out_type;
      prev_code_q <= w_out_code;
      cnt_q       <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= c_st_idle;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_scan_end && w_stable) begin
      if (state_q == c_st_idle && w_out_type == c_out_single) begin
        state_d = c_st_pressed;
      end else if (state_q == c_st_pressed && w_out_type == c_out_none) begin
        state_d = c_st_idle;
      end
    end
  end

  always_comb begin
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    if (w_scan_end && w_stable && state_q == c_st_idle && w_out_type == c_out_single) begin
      key_valid_d = 1'b1;
      key_code_d  = w_out_code;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == c_st_pressed);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : keypad scanner bench with a keypad model and scan-level reference
// Revision 1.0
// ============================================================================
module tb_keypad_scanner;

  localparam int DEB  = 3;
  localparam int SCAN = 16;
  localparam logic [63:0] COL_SEQ = 64'h7777_BBBB_DDDD_EEEE;
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                        4'h4, 4'h5, 4'h6, 4'hB,
                                        4'h7, 4'h8, 4'h9, 4'hC,
                                        4'h0, 4'hF, 4'hE, 4'hD};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int   hist_t[$];
  int   hist_c[$];
  bit   m_held  = 1'b0;
  bit   m_pulse = 1'b0;
  logic [3:0] m_code = 4'h0;

  logic [15:0] obs_valid, obs_held;
  logic [63:0] obs_codes, obs_cols;

  keypad_scanner #(.CLK_FREQ(16), .SCAN_RATE(1), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Passive matrix: a row reads low when a pressed key joins it to a driven-low column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
  end

  function automatic logic [15:0] key(input int r, input int c);
    return 16'd1 << (r*4 + c);
  endfunction

  task automatic model_reset();
    hist_t.delete();
    hist_c.delete();
    m_held  = 1'b0;
    m_pulse = 1'b0;
    m_code  = 4'h0;
  endtask

  // A key is accepted/released when the last DEB scan outcomes are identical.
  task automatic model_scan(input logic [15:0] keys);
    int n;
    int code;
    int t;
    bit stable;
    n = 0;
    code = 0;
    for (int i = 0; i < 16; i++)
      if (keys[i]) begin
        n++;
        code = int'(KEYMAP[i]);
      end
    t = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    if (t != 1) code = 0;
    hist_t.push_back(t);
    hist_c.push_back(code);
    if (hist_t.size() > DEB) begin
      void'(hist_t.pop_front());
      void'(hist_c.pop_front());
    end
    stable = (hist_t.size() == DEB);
    foreach (hist_t[i])
      if (hist_t[i] != t || hist_c[i] != code) stable = 1'b0;
    m_pulse = 1'b0;
    if (!m_held && stable && t == 1) begin
      m_pulse = 1'b1;
      m_held  = 1'b1;
      m_code  = 4'(code);
    end else if (m_held && stable && t == 0) begin
      m_held = 1'b0;
    end
  endtask

  // Runs one full scan starting at cycle 0, recording outputs each cycle.
  task automatic run_scan(input logic [15:0] keys);
    pressed = keys;
    for (int k = 0; k < SCAN; k++) begin
      obs_valid[k]        = key_valid;
      obs_held[k]         = key_held;
      obs_codes[4*k +: 4] = key_code;
      obs_cols[4*k +: 4]  = col;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b want 1110", col); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
    rst = 1'b1;
    model_reset();
    for (int s = 0; s < 3; s++) begin
      run_scan(16'h0);
      n_checks += 4;
      if (obs_cols !== COL_SEQ) begin n_fail++; $display("FAIL idle_col scan %0d: got %h want %h", s, obs_cols, COL_SEQ); end
      if (obs_valid !== 16'h0) begin n_fail++; $display("FAIL idle_valid scan %0d: got %h want 0", s, obs_valid); end
      if (obs_held !== 16'h0) begin n_fail++; $display("FAIL idle_held scan %0d: got %h want 0", s, obs_held); end
      if (obs_codes !== 64'h0) begin n_fail++; $display("FAIL idle_code scan %0d: got %h want 0", s, obs_codes); end
      model_scan(16'h0);
    end
  endtask

  task automatic test_single_press();
    int pulses;
    pulses = 0;
    for (int s = 0; s < 10; s++) begin
      logic [15:0] k;
      k = (s < 6) ? key(1, 1) : 16'h0;
      run_scan(k);
      pulses += $countones(obs_valid);
      n_checks += 3;
      if (obs_valid !== (m_pulse ? 16'h1 : 16'h0)) begin n_fail++; $display("FAIL five_valid scan %0d: got %h want %h", s, obs_valid, m_pulse); end
      if (obs_held !== {16{m_held}}) begin n_fail++; $display("FAIL five_held scan %0d: got %h want %b", s, obs_held, m_held); end
      if (obs_codes !== {16{m_code}}) begin n_fail++; $display("FAIL five_code scan %0d: got %h want %h", s, obs_codes, m_code); end
      model_scan(k);
    end
    run_scan(16'h0);
    n_checks += 4;
    if (pulses != 1) begin n_fail++; $display("FAIL five_pulse_count: got %0d want 1", pulses); end
    if (obs_codes !== {16{4'h5}}) begin n_fail++; $display("FAIL five_final_code: got %h want 5", obs_codes); end
    if (obs_held !== 16'h0) begin n_fail++; $display("FAIL five_final_held: got %h want 0", obs_held); end
    if (obs_valid !== 16'h0) begin n_fail++; $display("FAIL five_final_valid: got %h want 0", obs_valid); end
    model_scan(16'h0);
  endtask

  task automatic test_bounce();
    int early, late;
    early = 0;
    late  = 0;
    for (int s = 0; s < 12; s++) begin
      logic [15:0] k;
      k = (s < 4) ? ((s % 2 == 0) ? key(0, 3) : 16'h0) : ((s < 8) ? key(0, 3) : 16'h0);
      run_scan(k);
      if (s < 7) early += $countones(obs_valid); else late += $countones(obs_valid);
      n_checks += 3;
      if (obs_valid !== (m_pulse ? 16'h1 : 16'h0)) begin n_fail++; $display("FAIL bounce_valid scan %0d: got %h want %h", s, obs_valid, m_pulse); end
      if (obs_held !== {16{m_held}}) begin n_fail++; $display("FAIL bounce_held scan %0d: got %h want %b", s, obs_held, m_held); end
      if (obs_codes !== {16{m_code}}) begin n_fail++; $display("FAIL bounce_code scan %0d: got %h want %h", s, obs_codes, m_code); end
      if (s == 7) begin
        n_checks++;
        if (obs_valid !== 16'h1 || obs_codes[3:0] !== 4'hA) begin n_fail++; $display("FAIL bounce_accept: valid %h code %h want 0001 A", obs_valid, obs_codes[3:0]); end
      end
      model_scan(k);
    end
    n_checks += 2;
    if (early != 0) begin n_fail++; $display("FAIL bounce_early_pulses: got %0d want 0", early); end
    if (late != 1) begin n_fail++; $display("FAIL bounce_late_pulses: got %0d want 1", late); end
  endtask

  task automatic test_multi();
    int pulses;
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      run_scan(key(0, 0) | key(0, 1));
      pulses += $countones(obs_valid);
      n_checks += 3;
      if (obs_held !== 16'h0) begin n_fail++; $display("FAIL multi_held scan %0d: got %h want 0", s, obs_held); end
      if (obs_codes !== {16{4'hA}}) begin n_fail++; $display("FAIL multi_code scan %0d: got %h want A", s, obs_codes); end
      if (obs_valid !== (m_pulse ? 16'h1 : 16'h0)) begin n_fail++; $display("FAIL multi_valid scan %0d: got %h want %h", s, obs_valid, m_pulse); end
      model_scan(key(0, 0) | key(0, 1));
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL multi_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_no_rollover();
    int mid, fin;
    mid = 0;
    fin = 0;
    for (int s = 0; s < 20; s++) begin
      logic [15:0] k;
      if (s < 4)       k = key(2, 0);
      else if (s < 6)  k = key(2, 0) | key(2, 1);
      else if (s < 11) k = key(2, 1);
      else if (s < 14) k = 16'h0;
      else if (s < 18) k = key(2, 1);
      else             k = 16'h0;
      run_scan(k);
      if (s >= 4 && s < 14) mid += $countones(obs_valid);
      if (s >= 14) fin += $countones(obs_valid);
      n_checks += 3;
      if (obs_valid !== (m_pulse ? 16'h1 : 16'h0)) begin n_fail++; $display("FAIL roll_valid scan %0d: got %h want %h", s, obs_valid, m_pulse); end
      if (obs_held !== {16{m_held}}) begin n_fail++; $display("FAIL roll_held scan %0d: got %h want %b", s, obs_held, m_held); end
      if (obs_codes !== {16{m_code}}) begin n_fail++; $display("FAIL roll_code scan %0d: got %h want %h", s, obs_codes, m_code); end
      if (s == 17) begin
        n_checks++;
        if (obs_valid !== 16'h1 || obs_codes[3:0] !== 4'h8) begin n_fail++; $display("FAIL roll_accept8: valid %h code %h want 0001 8", obs_valid, obs_codes[3:0]); end
      end
      model_scan(k);
    end
    n_checks += 2;
    if (mid != 0) begin n_fail++; $display("FAIL roll_mid_pulses: got %0d want 0", mid); end
    if (fin != 1) begin n_fail++; $display("FAIL roll_final_pulses: got %0d want 1", fin); end
  endtask

  task automatic test_reset_mid_press();
    int pulses;
    for (int s = 0; s < 4; s++) begin
      run_scan(key(3, 0));
      model_scan(key(3, 0));
    end
    n_checks++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL rmp_held_before: got %b want 1", key_held); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks += 4;
    if (col !== 4'b1110) begin n_fail++; $display("FAIL rmp_col: got %b want 1110", col); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_valid: got %b want 0", key_valid); end
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL rmp_held: got %b want 0", key_held); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL rmp_code: got %h want 0", key_code); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    pulses = 0;
    for (int s = 0; s < 5; s++) begin
      run_scan(key(3, 0));
      pulses += $countones(obs_valid);
      n_checks += 3;
      if (obs_valid !== (m_pulse ? 16'h1 : 16'h0)) begin n_fail++; $display("FAIL rmp_valid scan %0d: got %h want %h", s, obs_valid, m_pulse); end
      if (obs_held !== {16{m_held}}) begin n_fail++; $display("FAIL rmp_held scan %0d: got %h want %b", s, obs_held, m_held); end
      if (obs_codes !== {16{m_code}}) begin n_fail++; $display("FAIL rmp_code scan %0d: got %h want %h", s, obs_codes, m_code); end
      if (s == 3) begin
        n_checks++;
        if (obs_valid !== 16'h1 || obs_codes[3:0] !== 4'h0 || obs_held[0] !== 1'b1) begin n_fail++; $display("FAIL rmp_fresh: valid %h code %h held %b want 0001 0 1", obs_valid, obs_codes[3:0], obs_held[0]); end
      end
      model_scan(key(3, 0));
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL rmp_pulses: got %0d want 1", pulses); end
    for (int s = 0; s < 4; s++) begin
      run_scan(16'h0);
      model_scan(16'h0);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 40; run++) begin
      logic [15:0] k;
      int sel, len, a, b;
      sel = int'($urandom_range(0, 3));
      a   = int'($urandom_range(0, 15));
      b   = (a + 1 + int'($urandom_range(0, 14))) % 16;
      case (sel)
        0:       k = 16'h0;
        3:       k = (16'd1 << a) | (16'd1 << b);
        default: k = 16'd1 << a;
      endcase
      len = int'($urandom_range(1, 5));
      for (int s = 0; s < len; s++) begin
        run_scan(k);
        n_checks += 4;
        if (obs_cols !== COL_SEQ) begin n_fail++; $display("FAIL rand_col run %0d: got %h want %h", run, obs_cols, COL_SEQ); end
        if (obs_valid !== (m_pulse ? 16'h1 : 16'h0)) begin n_fail++; $display("FAIL rand_valid run %0d keys %h: got %h want %h", run, k, obs_valid, m_pulse); end
        if (obs_held !== {16{m_held}}) begin n_fail++; $display("FAIL rand_held run %0d keys %h: got %h want %b", run, k, obs_held, m_held); end
        if (obs_codes !== {16{m_code}}) begin n_fail++; $display("FAIL rand_code run %0d keys %h: got %h want %h", run, k, obs_codes, m_code); end
        model_scan(k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_no_rollover();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
